// File: rtl/alu_test_sequencer.sv
// Exhaustive ALU stimulus sequencer: sweeps every (ALUOp, R2, R3) vector for ALUOp 0-6,
// waits for the ALU and comparator to settle, then tallies mismatches and keeps the first failure.
module alu_test_sequencer #(
   parameter int word_size = 5,
   parameter int SETTLE    = 2,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 error_flag,
   input  logic [word_size-1:0] error_bits,
   output logic [word_size-1:0] R2,
   output logic [word_size-1:0] R3,
   output logic [2:0]           ALUOp,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     err_count,
   output logic                 first_fail_valid,
   output logic [2:0]           first_fail_op,
   output logic [word_size-1:0] first_fail_r2,
   output logic [word_size-1:0] first_fail_r3,
   output logic [word_size-1:0] first_fail_bits
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // The settle counter only ever needs to hold 0..SETTLE-1.
   localparam int              SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE - 1);
   localparam logic [2:0]      OP_LAST = 3'd6;

   logic [1:0]           state;
   logic [SC_W-1:0]      settle_cnt;
   logic                 last_vector;
   logic [word_size-1:0] next_r2;
   logic [word_size-1:0] next_r3;
   logic [2:0]           next_op;
   logic                 count_full;

   assign last_vector = (ALUOp == OP_LAST) && (&R2) && (&R3);
   assign count_full  = &err_count;

   // R3 is the fastest digit; carries ripple into R2 and then into ALUOp.
   always_comb begin
      next_r3 = R3 + 1'b1;
      next_r2 = R2;
      next_op = ALUOp;
      if (&R3) begin
         next_r2 = R2 + 1'b1;
         if (&R2) begin
            next_op = ALUOp + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         settle_cnt       <= '0;
         R2               <= '0;
         R3               <= '0;
         ALUOp            <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_op    <= '0;
         first_fail_r2    <= '0;
         first_fail_r3    <= '0;
         first_fail_bits  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_op    <= '0;
                  first_fail_r2    <= '0;
                  first_fail_r3    <= '0;
                  first_fail_bits  <= '0;
                  done             <= 1'b0;
                  busy             <= 1'b1;
                  R2               <= '0;
                  R3               <= '0;
                  ALUOp            <= '0;
                  settle_cnt       <= '0;
                  state            <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               if (settle_cnt == SC_LAST) begin
                  state <= S_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            S_CHECK: begin
               // The first failure of a sweep is sticky; later failures only count.
               if (error_flag) begin
                  if (!count_full) begin
                     err_count <= err_count + 1'b1;
                  end
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_op    <= ALUOp;
                     first_fail_r2    <= R2;
                     first_fail_r3    <= R3;
                     first_fail_bits  <= error_bits;
                  end
               end
               if (last_vector) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  R2         <= next_r2;
                  R3         <= next_r3;
                  ALUOp      <= next_op;
                  settle_cnt <= '0;
                  state      <= S_SETTLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Randomized self-checking bench for alu_test_sequencer: a fault-injecting comparator stand-in
// feeds error_flag back from the applied vector, and a loop-level sweep model predicts the results.
module tb_alu_test_sequencer;

   localparam int W      = 3;
   localparam int S      = 2;
   localparam int CW     = 8;
   localparam int NV     = 7 * (1 << (2 * W));
   localparam int TOTAL  = NV * (S + 1);
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic          error_flag;
   logic [W-1:0]  error_bits;
   logic [W-1:0]  r2;
   logic [W-1:0]  r3;
   logic [2:0]    alu_op;
   logic          busy;
   logic          done;
   logic [CW-1:0] err_count;
   logic          ff_valid;
   logic [2:0]    ff_op;
   logic [W-1:0]  ff_r2;
   logic [W-1:0]  ff_r3;
   logic [W-1:0]  ff_bits;

   int num_checks = 0;
   int num_errors = 0;
   int fault_mode = 0;
   int rand_mul   = 1;
   int rand_add   = 0;
   int rand_mod   = 7;

   int           exp_count;
   logic         exp_valid;
   int           exp_op;
   int           exp_r2;
   int           exp_r3;
   logic [W-1:0] exp_bits;

   alu_test_sequencer #(.word_size(W), .SETTLE(S), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .error_flag       (error_flag),
      .error_bits       (error_bits),
      .R2               (r2),
      .R3               (r3),
      .ALUOp            (alu_op),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count),
      .first_fail_valid (ff_valid),
      .first_fail_op    (ff_op),
      .first_fail_r2    (ff_r2),
      .first_fail_r3    (ff_r3),
      .first_fail_bits  (ff_bits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparator stand-in: mismatch response as a pure function of the applied vector.
   function automatic logic [W:0] fault_resp(input int mode, input int op, input int a, input int b);
      int idx;
      idx = (op << (2 * W)) + (a << W) + b;
      case (mode)
         1: return (op == 2 && a == 3 && b == 4) ? {1'b1, W'(4)} : '0;
         2: return {1'b1, {W{1'b1}}};
         3: return (((idx * rand_mul + rand_add) % rand_mod) == 0) ? {1'b1, W'(idx * 5 + rand_add)} : '0;
         default: return '0;
      endcase
   endfunction

   always @(fault_mode or rand_mul or rand_add or rand_mod or alu_op or r2 or r3) begin
      {error_flag, error_bits} = fault_resp(fault_mode, int'(alu_op), int'(r2), int'(r3));
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Walks the whole vector space in sweep order to predict count and first failure.
   task automatic computeExpected(input int mode);
      logic [W:0] resp;
      exp_count = 0;
      exp_valid = 1'b0;
      exp_op = 0; exp_r2 = 0; exp_r3 = 0; exp_bits = '0;
      for (int op = 0; op < 7; op++)
         for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++) begin
               resp = fault_resp(mode, op, a, b);
               if (resp[W]) begin
                  if (exp_count < CMAX) exp_count++;
                  if (!exp_valid) begin
                     exp_valid = 1'b1;
                     exp_op = op; exp_r2 = a; exp_r3 = b; exp_bits = resp[W-1:0];
                  end
               end
            end
   endtask

   task automatic applyStimulus(input int mode, input int ignore_at);
      int v;
      int bad;
      int first_bad;
      logic exp_busy;
      fault_mode = mode;
      computeExpected(mode);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("clear_count", err_count, 0);
      checkOutput("clear_valid", ff_valid, 0);
      checkOutput("clear_done", done, 0);
      bad = 0;
      first_bad = -1;
      for (int k = 0; k <= TOTAL; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == ignore_at);
         v = (k < TOTAL) ? k / (S + 1) : NV - 1;
         exp_busy = (k < TOTAL);
         if (busy !== exp_busy || done !== !exp_busy ||
             int'(alu_op) != v / (1 << (2 * W)) ||
             int'(r2) != (v / (1 << W)) % (1 << W) ||
             int'(r3) != v % (1 << W)) begin
            bad++;
            if (first_bad < 0) first_bad = k;
         end
      end
      start = 1'b0;
      checkOutput("seq_bad_cycles", bad, 0);
      if (bad != 0) $display("[TB] first bad sequence cycle %0d", first_bad);
      checkOutput("err_count", err_count, exp_count);
      checkOutput("ff_valid", ff_valid, exp_valid);
      checkOutput("ff_op", ff_op, exp_op);
      checkOutput("ff_r2", ff_r2, exp_r2);
      checkOutput("ff_r3", ff_r3, exp_r3);
      checkOutput("ff_bits", ff_bits, exp_bits);
      repeat (3) @(negedge clk);
      checkOutput("done_hold", done, 1);
      checkOutput("busy_idle", busy, 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_count"}, err_count, 0);
      checkOutput({tag, "_valid"}, ff_valid, 0);
      checkOutput({tag, "_vector"}, {alu_op, r2, r3}, 0);
      checkOutput({tag, "_ff"}, {ff_op, ff_r2, ff_r3, ff_bits}, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(0, 500);
      applyStimulus(1, -1);
      applyStimulus(2, -1);
      for (int i = 0; i < 2; i++) begin
         rand_mul = 2 * $urandom_range(0, 12) + 1;
         rand_add = $urandom_range(0, 255);
         rand_mod = $urandom_range(5, 20);
         applyStimulus(3, (i == 1) ? 700 : -1);
      end

      // Asynchronous reset partway through a faulty sweep.
      fault_mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      checkOutput("pre_rst_valid", ff_valid, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkAllZero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, -1);

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule

// File: doc/alu_test_sequencer.md
# alu_test_sequencer

Exhaustive stimulus sequencer and result collector for the ALU checking path. It drives every (ALUOp, R2, R3) combination for ALUOp 0–6 into the ALU under test and the ideal-ALU comparator in parallel. For each vector it samples the comparator's `error_flag`/`error_bits`, counts mismatches and latches the first failing vector. It sits directly upstream of the comparator: its `R2`/`R3`/`ALUOp` outputs are that stage's operand and opcode inputs.

## Interface
- `word_size`, default 5: operand width; must match the comparator.
- `SETTLE`, default 2: wait cycles after a vector is applied before sampling. Legal range ≥1.
- `CNT_W`, default 16: width of the mismatch counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that launches a sweep.
- `error_flag` input 1: comparator mismatch flag for the current vector.
- `error_bits` input word_size: comparator per-bit mismatch.
- `R2` output word_size: operand A driven to ALU and comparator.
- `R3` output word_size: operand B.
- `ALUOp` output 3: opcode; takes values 0–6 only.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep complete; held until the next accepted `start` or `rst`.
- `err_count` output CNT_W: number of failing vectors, saturating.
- `first_fail_valid` output 1: a failure has been latched.
- `first_fail_op` output 3: opcode of the first failing vector.
- `first_fail_r2` output word_size: R2 of the first failing vector.
- `first_fail_r3` output word_size: R3 of the first failing vector.
- `first_fail_bits` output word_size: `error_bits` of the first failing vector.

## Operation
- All outputs are registered.
- On `rst`, every output and internal register is 0 and the FSM is in IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `start`=1 → clear `err_count`, all `first_fail_*` and `done`.
  - Load vector (ALUOp=0, R2=0, R3=0); settle counter=0; go to SETTLE.
  - `busy`=1 from the next cycle.
- SETTLE:
  - Settle counter increments each cycle.
  - When it reaches SETTLE-1, go to CHECK.
- CHECK, one cycle: sample `error_flag` and `error_bits` at the closing edge.
  - If `error_flag`=1: `err_count` increments, saturating at 2^CNT_W-1.
  - If `error_flag`=1 and `first_fail_valid`=0: latch the current ALUOp/R2/R3/`error_bits` and set `first_fail_valid`. It is never overwritten within a sweep.
  - If the vector is the last one (ALUOp=6, R2=R3=all-ones): go to DONE.
  - Otherwise advance the vector and return to SETTLE with the counter at 0.
- Vector order:
  - R3 increments fastest; R3 wraps all-ones→0 and carries into R2.
  - R2 wraps all-ones→0 and carries into ALUOp.
  - ALUOp never reaches 7.
- DONE: `busy`=0, `done`=1; vector outputs hold the last vector.
  - `start` in DONE behaves as in IDLE (restart, with results cleared).
- `start` while `busy`=1 is ignored.
- Async `rst` mid-sweep aborts immediately: all outputs 0, IDLE, no partial results retained.

## Timing
- A vector is stable on `R2`/`R3`/`ALUOp` for SETTLE+1 cycles before it is sampled: SETTLE cycles in SETTLE plus 1 in CHECK.
- Cycles per vector: SETTLE+1.
- Total sweep length: 7·2^(2·word_size)·(SETTLE+1) cycles from the first SETTLE cycle to the DONE entry edge.
- Defaults: 7168 vectors, 21504 cycles.
- `start` sampled at edge t → `busy`=1 and vector (0,0,0) visible after edge t.
- `done` rises at the same edge that `busy` falls.
- A counter update and a first-fail capture from the same CHECK cycle are visible together on the following cycle.

## Test plan
- Clean sweep: comparator fed back with the ideal result, so `error_flag`=0 always; defaults; pulse `start`.
  - `busy` high for 21504 cycles, then `done`=1.
  - `err_count`=0, `first_fail_valid`=0.
- Single fault: force `error_flag`=1 and `error_bits`=5'h04 only when ALUOp=2, R2=3, R3=4.
  - `err_count`=1, `first_fail_valid`=1.
  - `first_fail_op`=2, `first_fail_r2`=3, `first_fail_r3`=4, `first_fail_bits`=5'h04.
- Stuck-at fault: `error_flag`=1 constantly, CNT_W=8.
  - `err_count` saturates at 255.
  - First fail latched as (0,0,0).
- Order and stability: monitor the outputs with SETTLE=3, word_size=2.
  - Each vector held 4 cycles.
  - Sequence runs (0,0,0),(0,0,1)…(0,3,3),(1,0,0)…(6,3,3).
  - 112 vectors total; ALUOp=7 never appears.
- Reset mid-run: assert `rst` asynchronously at cycle 100, between clock edges.
  - All outputs 0 before the next edge.
  - A subsequent `start` completes a full clean sweep.
- Control corner cases:
  - `start` pulsed while `busy`: ignored; sweep length unchanged.
  - `start` in DONE after a faulty sweep: `err_count` and `first_fail_*` cleared, new sweep begins.
